// File: rtl/sr_bank.sv
// sr_bank: bank of CH registered SR state bits with a global force-clear,
// selectable S=R=1 resolution and a handshaked one-channel-per-cycle init sweep.
//
// Parameters:
//   CH   - number of channels (1..32)
//   PRIO - S=R=1 resolution: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   s, r     - per-channel set / reset requests
//   is0      - synchronous global force-clear (aborts any sweep)
//   init_req - starts an init sweep, honoured only in IDLE
//   q        - registered channel state
//   qn       - combinational ~q
//   busy     - high while the sweep is running
//   done     - one-cycle pulse when the sweep completes
//   conflict - (SR_BANK_CONFLICT_FLAG_EN only) sticky per-channel S=R=1 flag
//
// Optional feature macro: SR_BANK_CONFLICT_FLAG_EN

module sr_bank #(
    parameter int unsigned CH   = 8,
    parameter int unsigned PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] s,
    input  logic [CH-1:0] r,
    input  logic          is0,
    input  logic          init_req,
    output logic [CH-1:0] q,
    output logic [CH-1:0] qn,
    output logic          busy,
    output logic          done
`ifdef SR_BANK_CONFLICT_FLAG_EN
    ,
    output logic [CH-1:0] conflict
`endif
);

    localparam int unsigned IW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(CH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CH-1:0] q_d;
    logic          busy_d;
    logic          done_d;
    logic [CH-1:0] swept;

    function automatic logic sr_resolve(input logic cur, input logic set, input logic clr);
        logic nxt;
        case ({set, clr})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (PRIO)
                    0:       nxt = 1'b0;
                    1:       nxt = 1'b1;
                    2:       nxt = cur;
                    default: nxt = ~cur;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Channels at or below the sweep index are forced to 0 and ignore s/r.
    always_comb begin
        swept = '0;
        for (int i = 0; i < int'(CH); i++) begin
            swept[i] = (state_q == StSweep) && (IW'(i) <= idx_q);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        q_d     = q;
        if (is0) begin
            q_d     = '0;
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                q_d[i] = swept[i] ? 1'b0 : sr_resolve(q[i], s[i], r[i]);
            end
            case (state_q)
                StIdle: begin
                    if (init_req) begin
                        state_d = StSweep;
                        idx_d   = '0;
                    end
                end
                StSweep: begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d == StSweep);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            q       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            q       <= q_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign qn = ~q;

`ifdef SR_BANK_CONFLICT_FLAG_EN
    logic [CH-1:0] conflict_d;

    // Clears (is0, sweep) win over a set; a set wins over hold.
    always_comb begin
        conflict_d = conflict;
        if (is0) begin
            conflict_d = '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (swept[i]) begin
                    conflict_d[i] = 1'b0;
                end else if (s[i] && r[i]) begin
                    conflict_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict <= '0;
        end else begin
            conflict <= conflict_d;
        end
    end
`endif

endmodule

// File: tb/tb_sr_bank.sv
module tb_sr_bank;

    localparam int NP = 4;

    logic       clk;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;
    logic       is0;
    logic       init_req;

    logic [3:0] q_dut    [NP];
    logic [3:0] qn_dut   [NP];
    logic       busy_dut [NP];
    logic       done_dut [NP];
`ifdef SR_BANK_CONFLICT_FLAG_EN
    logic [3:0] conf_dut [NP];
`endif

    int total;
    int bad;

    // Reference model: one state vector per PRIO, shared sweep bookkeeping.
    logic [3:0] m_q    [NP];
    logic [3:0] m_conf [NP];
    int         m_mode;  // 0 idle, 1 sweeping, 2 done
    int         m_pos;   // channel cleared on the next sweep edge

    for (genvar p = 0; p < NP; p++) begin : g_dut
        sr_bank #(
            .CH  (4),
            .PRIO(p)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .s       (s),
            .r       (r),
            .is0     (is0),
            .init_req(init_req),
            .q       (q_dut[p]),
            .qn      (qn_dut[p]),
            .busy    (busy_dut[p]),
            .done    (done_dut[p])
`ifdef SR_BANK_CONFLICT_FLAG_EN
            ,
            .conflict(conf_dut[p])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_bit(int prio, logic cur, logic sb, logic rb);
        if (sb && !rb) return 1'b1;
        if (!sb && rb) return 1'b0;
        if (!sb && !rb) return cur;
        if (prio == 0) return 1'b0;
        if (prio == 1) return 1'b1;
        if (prio == 2) return cur;
        return ~cur;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_q[p]    = 4'b0000;
            m_conf[p] = 4'b0000;
        end
        m_mode = 0;
        m_pos  = 0;
    endtask

    task automatic model_step();
        if (is0) begin
            model_reset();
            return;
        end
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_mode == 1 && i <= m_pos) begin
                    m_q[p][i]    = 1'b0;
                    m_conf[p][i] = 1'b0;
                end else begin
                    m_q[p][i] = model_bit(p, m_q[p][i], s[i], r[i]);
                    if (s[i] && r[i]) m_conf[p][i] = 1'b1;
                end
            end
        end
        if (m_mode == 0) begin
            if (init_req) begin
                m_mode = 1;
                m_pos  = 0;
            end
        end else if (m_mode == 1) begin
            if (m_pos == 3) m_mode = 2;
            else m_pos = m_pos + 1;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s = '0; r = '0; is0 = 1'b0; init_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_dut[p] !== 4'b0000 || qn_dut[p] !== 4'b1111 ||
                busy_dut[p] !== 1'b0 || done_dut[p] !== 1'b0) begin
                bad++;
                $display("FAIL reset p%0d: q=%b qn=%b busy=%b done=%b want 0000 1111 0 0",
                         p, q_dut[p], qn_dut[p], busy_dut[p], done_dut[p]);
            end
        end
    endtask

    task automatic test_prio();
        logic [3:0] want [NP];
        s = 4'b1111; r = 4'b0000;
        tick();
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_dut[p] !== 4'b1111) begin
                bad++;
                $display("FAIL prio_set p%0d: q=%b want 1111", p, q_dut[p]);
            end
        end
        want[0] = 4'b1100; want[1] = 4'b1111; want[2] = 4'b1111; want[3] = 4'b1100;
        s = 4'b0011; r = 4'b0011;
        tick();
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_dut[p] !== want[p]) begin
                bad++;
                $display("FAIL prio_conflict p%0d: q=%b want %b", p, q_dut[p], want[p]);
            end
        end
        // Second S=R=1 edge: toggle mode flips back, others stay put.
        tick();
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_dut[p] !== m_q[p] || qn_dut[p] !== ~m_q[p]) begin
                bad++;
                $display("FAIL prio_repeat p%0d: q=%b qn=%b want q=%b", p, q_dut[p],
                         qn_dut[p], m_q[p]);
            end
        end
        s = '0; r = '0;
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] want_q [5];
        logic       want_b [5];
        logic       want_d [5];
        logic [3:0] drive_s [5];
        want_q[0] = 4'b1110; want_b[0] = 1'b1; want_d[0] = 1'b0; drive_s[0] = 4'b1000;
        want_q[1] = 4'b1100; want_b[1] = 1'b1; want_d[1] = 1'b0; drive_s[1] = 4'b0001;
        want_q[2] = 4'b1000; want_b[2] = 1'b1; want_d[2] = 1'b0; drive_s[2] = 4'b0000;
        want_q[3] = 4'b0000; want_b[3] = 1'b0; want_d[3] = 1'b1; drive_s[3] = 4'b0000;
        want_q[4] = 4'b0000; want_b[4] = 1'b0; want_d[4] = 1'b0; drive_s[4] = 4'b0000;
        s = 4'b1111; r = 4'b0000;
        tick();
        s = 4'b0000; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int p = 0; p < NP; p++) begin
            total++;
            if (busy_dut[p] !== 1'b1 || q_dut[p] !== 4'b1111) begin
                bad++;
                $display("FAIL sweep_start p%0d: busy=%b q=%b want 1 1111", p, busy_dut[p],
                         q_dut[p]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            s = drive_s[c];
            tick();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (q_dut[p] !== want_q[c] || busy_dut[p] !== want_b[c] ||
                    done_dut[p] !== want_d[c]) begin
                    bad++;
                    $display("FAIL sweep_c%0d p%0d: q=%b busy=%b done=%b want %b %b %b", c, p,
                             q_dut[p], busy_dut[p], done_dut[p], want_q[c], want_b[c],
                             want_d[c]);
                end
            end
        end
        s = '0;
    endtask

    task automatic test_abort();
        bit seen;
        s = 4'b1111;
        tick();
        s = 4'b0000; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (2) tick();
        is0 = 1'b1;
        tick();
        is0 = 1'b0;
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_dut[p] !== 4'b0000 || busy_dut[p] !== 1'b0 || done_dut[p] !== 1'b0) begin
                bad++;
                $display("FAIL abort p%0d: q=%b busy=%b done=%b want 0000 0 0", p, q_dut[p],
                         busy_dut[p], done_dut[p]);
            end
        end
        seen = 0;
        repeat (6) begin
            tick();
            if (done_dut[0] !== 1'b0 || busy_dut[0] !== 1'b0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_quiet: busy/done activity after abort, want none");
        end
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        total++;
        if (busy_dut[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: busy=%b want 1", busy_dut[0]);
        end
        seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            tick();
            if (done_dut[0] === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL abort_done_timeout: done=%b want 1 within 8 cycles", done_dut[0]);
        end
        tick();
    endtask

    task automatic test_async_reset();
        s = 4'b1111;
        tick();
        s = 4'b0000; init_req = 1'b1;
        tick();
        init_req = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        for (int p = 0; p < NP; p++) begin
            total++;
            if (q_dut[p] !== 4'b0000 || qn_dut[p] !== 4'b1111 || busy_dut[p] !== 1'b0 ||
                done_dut[p] !== 1'b0) begin
                bad++;
                $display("FAIL async_rst p%0d: q=%b qn=%b busy=%b done=%b want 0000 1111 0 0",
                         p, q_dut[p], qn_dut[p], busy_dut[p], done_dut[p]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (busy_dut[0] !== 1'b0 || done_dut[0] !== 1'b0 || q_dut[0] !== 4'b0000) begin
            bad++;
            $display("FAIL async_release: busy=%b done=%b q=%b want 0 0 0000", busy_dut[0],
                     done_dut[0], q_dut[0]);
        end
    endtask

`ifdef SR_BANK_CONFLICT_FLAG_EN
    task automatic test_conflict();
        s = 4'b0101; r = 4'b0101;
        tick();
        s = '0; r = '0;
        tick();
        for (int p = 0; p < NP; p++) begin
            total++;
            if (conf_dut[p] !== 4'b0101) begin
                bad++;
                $display("FAIL conflict_sticky p%0d: conflict=%b want 0101", p, conf_dut[p]);
            end
        end
        is0 = 1'b1;
        tick();
        is0 = 1'b0;
        for (int p = 0; p < NP; p++) begin
            total++;
            if (conf_dut[p] !== 4'b0000) begin
                bad++;
                $display("FAIL conflict_clear p%0d: conflict=%b want 0000", p, conf_dut[p]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            s        = 4'($urandom);
            r        = 4'($urandom);
            is0      = ($urandom_range(0, 19) == 0);
            init_req = ($urandom_range(0, 5) == 0);
            tick();
            for (int p = 0; p < NP; p++) begin
                total++;
                if (q_dut[p] !== m_q[p] || qn_dut[p] !== ~m_q[p] ||
                    busy_dut[p] !== (m_mode == 1) || done_dut[p] !== (m_mode == 2)) begin
                    bad++;
                    $display("FAIL random c%0d p%0d: q=%b qn=%b busy=%b done=%b want q=%b mode=%0d",
                             c, p, q_dut[p], qn_dut[p], busy_dut[p], done_dut[p], m_q[p],
                             m_mode);
                end
`ifdef SR_BANK_CONFLICT_FLAG_EN
                total++;
                if (conf_dut[p] !== m_conf[p]) begin
                    bad++;
                    $display("FAIL random_conflict c%0d p%0d: conflict=%b want %b", c, p,
                             conf_dut[p], m_conf[p]);
                end
`endif
            end
        end
        s = '0; r = '0; is0 = 1'b0; init_req = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_prio();
        test_sweep();
        test_abort();
        test_async_reset();
`ifdef SR_BANK_CONFLICT_FLAG_EN
        test_conflict();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
